// File: rtl/yl3_serial_receiver_if.sv
// yl3_serial_receiver_if: serial pins from the YL-3 driver and decoded frame outputs
interface yl3_serial_receiver_if;
  logic DIO, SCK, RCK;
  logic [63:0] FRAME;
  logic [15:0] WORD;
  logic [2:0] DIGIT_IDX;
  logic WORD_VALID, FRAME_DONE, POS_ERR, CNT_ERR;
  modport master (output DIO, SCK, RCK,
                  input FRAME, WORD, WORD_VALID, DIGIT_IDX, FRAME_DONE, POS_ERR, CNT_ERR);
  modport slave (input DIO, SCK, RCK,
                 output FRAME, WORD, WORD_VALID, DIGIT_IDX, FRAME_DONE, POS_ERR, CNT_ERR);
endinterface

// File: rtl/yl3_serial_receiver.sv
// yl3_serial_receiver: oversampled 74HC595 stream decoder rebuilding an 8-digit segment frame
module yl3_serial_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] BLANK = 8'hFF
) (
  input logic CLK,
  input logic nRST,
  yl3_serial_receiver_if.slave bus
);
  logic [SYNC_STAGES-1:0] dio_sync, sck_sync, rck_sync;
  logic sck_h, rck_h, dio_s, sck_rise, rck_rise, one_hot, full;
  logic [15:0] shreg;
  logic [4:0] bitcnt;
  logic [7:0] mask, pos, new_mask;
  logic [2:0] idx;
  assign dio_s = dio_sync[SYNC_STAGES-1];
  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_h;
  assign rck_rise = rck_sync[SYNC_STAGES-1] & ~rck_h;
  assign pos = shreg[15:8];
  assign one_hot = (pos != 8'd0) && ((pos & (pos - 8'd1)) == 8'd0);
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (pos[i]) idx = 3'(i);
  end
  assign new_mask = mask | (8'd1 << idx);
  assign full = &new_mask;
  // edge flops reset high so a pin already high at release is not seen as a rise
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dio_sync <= '0;
      sck_sync <= '1;
      rck_sync <= '1;
      sck_h <= 1'b1;
      rck_h <= 1'b1;
      shreg <= '0;
      bitcnt <= '0;
      mask <= '0;
      bus.FRAME <= {8{BLANK}};
      bus.WORD <= '0;
      bus.DIGIT_IDX <= '0;
      bus.WORD_VALID <= 1'b0;
      bus.FRAME_DONE <= 1'b0;
      bus.POS_ERR <= 1'b0;
      bus.CNT_ERR <= 1'b0;
    end else begin
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], bus.DIO};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.SCK};
      rck_sync <= {rck_sync[SYNC_STAGES-2:0], bus.RCK};
      sck_h <= sck_sync[SYNC_STAGES-1];
      rck_h <= rck_sync[SYNC_STAGES-1];
      bus.WORD_VALID <= 1'b0;
      bus.FRAME_DONE <= 1'b0;
      bus.POS_ERR <= 1'b0;
      bus.CNT_ERR <= 1'b0;
      if (sck_rise) shreg <= {shreg[14:0], dio_s};
      if (rck_rise) bitcnt <= {4'd0, sck_rise};
      else if (sck_rise && bitcnt != 5'd31) bitcnt <= bitcnt + 5'd1;
      if (rck_rise) begin
        bus.WORD <= shreg;
        if (bitcnt != 5'd16) bus.CNT_ERR <= 1'b1;
        else begin
          bus.WORD_VALID <= 1'b1;
          if (!one_hot) bus.POS_ERR <= 1'b1;
          else begin
            bus.DIGIT_IDX <= idx;
            bus.FRAME[{~idx, 3'b000} +: 8] <= shreg[7:0];
            mask <= full ? 8'd0 : new_mask;
            bus.FRAME_DONE <= full;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_yl3_serial_receiver.sv
// tb_yl3_serial_receiver: directed and random serial streams checked against a digit-level model
module tb_yl3_serial_receiver;
  logic clk = 1'b0, nrst = 1'b0;
  yl3_serial_receiver_if bus();
  yl3_serial_receiver dut (.CLK(clk), .nRST(nrst), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int wv_n = 0, ce_n = 0, pe_n = 0, fd_n = 0;
  int e_wv = 0, e_ce = 0, e_pe = 0, e_fd = 0;
  logic [15:0] m_sh, e_word;
  int m_n;
  logic [7:0] m_frame [8];
  logic [7:0] m_seen;
  logic [2:0] e_idx;

  always @(negedge clk) begin
    if (bus.WORD_VALID) wv_n++;
    if (bus.CNT_ERR) ce_n++;
    if (bus.POS_ERR) pe_n++;
    if (bus.FRAME_DONE) fd_n++;
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sh = '0; m_n = 0; e_word = '0; e_idx = '0; m_seen = '0;
    for (int i = 0; i < 8; i++) m_frame[i] = 8'hFF;
  endtask

  task automatic model_shift(logic b);
    m_sh = {m_sh[14:0], b};
    m_n = (m_n < 31) ? m_n + 1 : 31;
  endtask

  task automatic model_latch();
    logic [7:0] p;
    p = m_sh[15:8];
    e_word = m_sh;
    if (m_n != 16) e_ce++;
    else begin
      e_wv++;
      if ($countones(p) != 1) e_pe++;
      else begin
        e_idx = 3'($clog2(p));
        m_frame[e_idx] = m_sh[7:0];
        m_seen[e_idx] = 1'b1;
        if (m_seen == 8'hFF) begin e_fd++; m_seen = '0; end
      end
    end
    m_n = 0;
  endtask

  function automatic logic [63:0] exp_frame();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[63-8*i -: 8] = m_frame[i];
    return f;
  endfunction

  task automatic check_all(string tag);
    chk({tag, "_wv"}, 64'(wv_n), 64'(e_wv));
    chk({tag, "_ce"}, 64'(ce_n), 64'(e_ce));
    chk({tag, "_pe"}, 64'(pe_n), 64'(e_pe));
    chk({tag, "_fd"}, 64'(fd_n), 64'(e_fd));
    chk({tag, "_word"}, 64'(bus.WORD), 64'(e_word));
    chk({tag, "_idx"}, 64'(bus.DIGIT_IDX), 64'(e_idx));
    chk({tag, "_frame"}, bus.FRAME, exp_frame());
  endtask

  task automatic send_bit(logic b);
    bus.DIO = b;
    tick(2);
    bus.SCK = 1'b1;
    model_shift(b);
    tick(4);
    bus.SCK = 1'b0;
    tick(2);
  endtask

  task automatic send_bits(logic [31:0] v, int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic latch(string tag);
    bus.RCK = 1'b1;
    model_latch();
    tick(4);
    bus.RCK = 1'b0;
    tick(4);
    check_all(tag);
  endtask

  initial begin
    logic [7:0] p;
    int n;
    bus.DIO = 1'b0; bus.SCK = 1'b0; bus.RCK = 1'b0;
    model_reset();
    tick(3);
    nrst = 1'b1;
    tick(4);
    check_all("reset");
    for (int i = 0; i < 8; i++) begin
      send_bits({16'h0, 8'(1 << i), 8'(8'hC0 + i)}, 16);
      latch("nom");
      chk("nom_idx_const", 64'(bus.DIGIT_IDX), 64'(i));
    end
    chk("nom_frame_const", bus.FRAME, 64'hC0C1C2C3C4C5C6C7);
    chk("nom_done_once", 64'(fd_n), 64'd1);
    send_bits($urandom, 15);
    latch("cnt15");
    send_bits($urandom, 17);
    latch("cnt17");
    send_bits(32'h04A4, 16);
    latch("cnt_ok");
    chk("cnt_digit2", 64'(bus.FRAME[47:40]), 64'hA4);
    send_bits(32'h005A, 16);
    latch("pos00");
    send_bits(32'h0333, 16);
    latch("pos03");
    send_bits(32'h1092, 16);
    bus.DIO = 1'b0;
    tick(2);
    bus.SCK = 1'b1; bus.RCK = 1'b1;
    model_latch();
    model_shift(1'b0);
    tick(4);
    bus.SCK = 1'b0; bus.RCK = 1'b0;
    tick(4);
    check_all("coin");
    chk("coin_word", 64'(bus.WORD), 64'h1092);
    send_bits(32'h2081, 15);
    latch("coin_next");
    chk("coin_next_word", 64'(bus.WORD), 64'h2081);
    send_bits($urandom, 9);
    bus.SCK = 1'b1; bus.RCK = 1'b1; nrst = 1'b0;
    tick(1);
    nrst = 1'b1;
    model_reset();
    tick(4);
    bus.SCK = 1'b0; bus.RCK = 1'b0;
    tick(4);
    check_all("rst_mid");
    send_bits(32'h4092, 16);
    latch("rst_word");
    chk("rst_frame", bus.FRAME, 64'hFFFF_FFFF_FFFF_92FF);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      send_bits({16'($urandom), p, 8'($urandom)}, n);
      latch("rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
